decodificador_assign: RTL and testbench

- Registered 5-bit to seven-segment decoder. Maps the 5-bit code {i1,i2,i3,i4,i5} (i1 = MSB) to a glyph on segments A..G.
- Codes 0–15 display hexadecimal digits. Codes 16–31 display a fixed set of letters and symbols.
- Sits between the switch/input logic and a single seven-segment digit driver.

---
 rtl/decodificador_pkg.sv | 50 +++++
 rtl/decodificador_assign_seg7_glyph_rom.sv | 48 ++++
 rtl/decodificador_assign.sv | 61 ++++++
 tb/tb_decodificador_assign.sv | 133 +++++++++++++
 4 files changed

// File: rtl/decodificador_pkg.sv
// Shared segment definitions for the seven-segment decoder: bit positions,
// the seg7_t vector type and the 32 glyph patterns ordered {A,B,C,D,E,F,G}.
package decodificador_pkg;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK    = 7'b0000000;

  localparam seg7_t GLYPH_0      = 7'b1111110;
  localparam seg7_t GLYPH_1      = 7'b0110000;
  localparam seg7_t GLYPH_2      = 7'b1101101;
  localparam seg7_t GLYPH_3      = 7'b1111001;
  localparam seg7_t GLYPH_4      = 7'b0110011;
  localparam seg7_t GLYPH_5      = 7'b1011011;
  localparam seg7_t GLYPH_6      = 7'b1011111;
  localparam seg7_t GLYPH_7      = 7'b1110000;
  localparam seg7_t GLYPH_8      = 7'b1111111;
  localparam seg7_t GLYPH_9      = 7'b1111011;
  localparam seg7_t GLYPH_A      = 7'b1110111;
  localparam seg7_t GLYPH_B      = 7'b0011111;
  localparam seg7_t GLYPH_C      = 7'b1001110;
  localparam seg7_t GLYPH_D      = 7'b0111101;
  localparam seg7_t GLYPH_E      = 7'b1001111;
  localparam seg7_t GLYPH_F      = 7'b1000111;
  localparam seg7_t GLYPH_H      = 7'b0110111;
  localparam seg7_t GLYPH_J      = 7'b0111100;
  localparam seg7_t GLYPH_L      = 7'b0001110;
  localparam seg7_t GLYPH_N      = 7'b0010101;
  localparam seg7_t GLYPH_O      = 7'b0011101;
  localparam seg7_t GLYPH_P      = 7'b1100111;
  localparam seg7_t GLYPH_R      = 7'b0000101;
  localparam seg7_t GLYPH_U      = 7'b0111110;
  localparam seg7_t GLYPH_Y      = 7'b0111011;
  localparam seg7_t GLYPH_DASH   = 7'b0000001;
  localparam seg7_t GLYPH_UNDER  = 7'b0001000;
  localparam seg7_t GLYPH_OVER   = 7'b1000000;
  localparam seg7_t GLYPH_EQ     = 7'b0001001;
  localparam seg7_t GLYPH_TRIPLE = 7'b1001001;
  localparam seg7_t GLYPH_BLANK  = 7'b0000000;
  localparam seg7_t GLYPH_LAMP   = 7'b1111111;

endpackage

// File: rtl/decodificador_assign_seg7_glyph_rom.sv
// Combinational 5-bit code to active-high seven-segment glyph lookup.
module seg7_glyph_rom
  import decodificador_pkg::*;
(
  input  logic [4:0] code,
  output seg7_t      glyph
);

  always_comb begin
    glyph = SEG_BLANK;
    case (code)
      5'd0:  glyph = GLYPH_0;
      5'd1:  glyph = GLYPH_1;
      5'd2:  glyph = GLYPH_2;
      5'd3:  glyph = GLYPH_3;
      5'd4:  glyph = GLYPH_4;
      5'd5:  glyph = GLYPH_5;
      5'd6:  glyph = GLYPH_6;
      5'd7:  glyph = GLYPH_7;
      5'd8:  glyph = GLYPH_8;
      5'd9:  glyph = GLYPH_9;
      5'd10: glyph = GLYPH_A;
      5'd11: glyph = GLYPH_B;
      5'd12: glyph = GLYPH_C;
      5'd13: glyph = GLYPH_D;
      5'd14: glyph = GLYPH_E;
      5'd15: glyph = GLYPH_F;
      5'd16: glyph = GLYPH_H;
      5'd17: glyph = GLYPH_J;
      5'd18: glyph = GLYPH_L;
      5'd19: glyph = GLYPH_N;
      5'd20: glyph = GLYPH_O;
      5'd21: glyph = GLYPH_P;
      5'd22: glyph = GLYPH_R;
      5'd23: glyph = GLYPH_U;
      5'd24: glyph = GLYPH_Y;
      5'd25: glyph = GLYPH_DASH;
      5'd26: glyph = GLYPH_UNDER;
      5'd27: glyph = GLYPH_OVER;
      5'd28: glyph = GLYPH_EQ;
      5'd29: glyph = GLYPH_TRIPLE;
      5'd30: glyph = GLYPH_BLANK;
      5'd31: glyph = GLYPH_LAMP;
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/decodificador_assign.sv
// Registered 5-bit to seven-segment decoder, one cycle latency.
// Define DECOD_ACTIVE_LOW_EN for inverted (common-anode) segment outputs.
module decodificador_assign
  import decodificador_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  input  logic i5,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic E,
  output logic F,
  output logic G
);

`ifdef DECOD_ACTIVE_LOW_EN
  localparam seg7_t SEG_RST = ~SEG_BLANK;
`else
  localparam seg7_t SEG_RST = SEG_BLANK;
`endif

  logic [4:0] code;
  seg7_t      glyph;
  seg7_t      seg_d;
  seg7_t      seg_q;

  assign code = {i1, i2, i3, i4, i5};

  seg7_glyph_rom u_rom (
    .code  (code),
    .glyph (glyph)
  );

  always_comb begin
    seg_d = glyph;
`ifdef DECOD_ACTIVE_LOW_EN
    seg_d = ~glyph;
`endif
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) seg_q <= SEG_RST;
    else     seg_q <= seg_d;
  end

  assign A = seg_q[SEG_A];
  assign B = seg_q[SEG_B];
  assign C = seg_q[SEG_C];
  assign D = seg_q[SEG_D];
  assign E = seg_q[SEG_E];
  assign F = seg_q[SEG_F];
  assign G = seg_q[SEG_G];

endmodule

// File: tb/tb_decodificador_assign.sv
// Self-checking bench for decodificador_assign: directed cases plus randomized
// codes and resets compared against a table-driven reference model.
module tb_decodificador_assign;

  logic clk = 1'b0;
  logic rst;
  logic i1, i2, i3, i4, i5;
  logic A, B, C, D, E, F, G;

  int n_checks = 0;
  int n_pass   = 0;

  // Glyph table {A..G} indexed by code value
  localparam logic [6:0] TBL [32] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
    7'b0110111, 7'b0111100, 7'b0001110, 7'b0010101,
    7'b0011101, 7'b1100111, 7'b0000101, 7'b0111110,
    7'b0111011, 7'b0000001, 7'b0001000, 7'b1000000,
    7'b0001001, 7'b1001001, 7'b0000000, 7'b1111111
  };

  logic [6:0] model_q;

  decodificador_assign dut (
    .clk (clk), .rst (rst),
    .i1 (i1), .i2 (i2), .i3 (i3), .i4 (i4), .i5 (i5),
    .A (A), .B (B), .C (C), .D (D), .E (E), .F (F), .G (G)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pol(input logic [6:0] v);
`ifdef DECOD_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic logic [6:0] segs();
    return {A, B, C, D, E, F, G};
  endfunction

  task automatic check_seg(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic drive(input logic r, input logic [4:0] c);
    @(negedge clk);
    rst = r;
    {i1, i2, i3, i4, i5} = c;
  endtask

  // Advance one edge, update model from what was sampled, compare.
  task automatic tick_check(input string tag);
    logic r_s;
    logic [4:0] c_s;
    r_s = rst;
    c_s = {i1, i2, i3, i4, i5};
    @(posedge clk);
    #1;
    model_q = r_s ? pol(7'b0000000) : pol(TBL[c_s]);
    check_seg(tag, segs(), model_q);
  endtask

  initial begin
    rst = 1'b1;
    {i1, i2, i3, i4, i5} = 5'd8;
    model_q = 7'b0;

    // Reset with code 8 present
    drive(1'b1, 5'd8); tick_check("reset_edge1");
    drive(1'b1, 5'd8); tick_check("reset_edge2");
    check_seg("reset_blank_const", segs(), pol(7'b0000000));
    drive(1'b0, 5'd8); tick_check("release_code8");
    check_seg("release_code8_const", segs(), pol(7'b1111111));

    // Ascending sweep of all codes
    for (int c = 0; c < 32; c++) begin
      drive(1'b0, 5'(c));
      tick_check($sformatf("sweep_%0d", c));
      if (c == 2)  check_seg("sweep_2_const",  segs(), pol(7'b1101101));
      if (c == 11) check_seg("sweep_11_const", segs(), pol(7'b0011111));
      if (c == 22) check_seg("sweep_22_const", segs(), pol(7'b0000101));
    end

    // Latency: new code must not show before the edge
    drive(1'b0, 5'd5); tick_check("lat_code5");
    drive(1'b0, 5'd30);
    #1 check_seg("lat_hold_before_edge", segs(), pol(7'b1011011));
    tick_check("lat_code30");
    check_seg("lat_code30_const", segs(), pol(7'b0000000));

    // Mid-stream reset pulse
    drive(1'b0, 5'd31); tick_check("mid_code31");
    drive(1'b1, 5'd31); tick_check("mid_rst_blank");
    check_seg("mid_rst_blank_const", segs(), pol(7'b0000000));
    drive(1'b0, 5'd31); tick_check("mid_restore");
    check_seg("mid_restore_const", segs(), pol(7'b1111111));

    // Bit order
    drive(1'b0, 5'b10000); tick_check("bit_msb");
    check_seg("bit_msb_const", segs(), pol(7'b0110111));
    drive(1'b0, 5'b00001); tick_check("bit_lsb");
    check_seg("bit_lsb_const", segs(), pol(7'b0110000));

`ifdef DECOD_ACTIVE_LOW_EN
    drive(1'b0, 5'd0); tick_check("al_code0");
    check_seg("al_code0_const", segs(), 7'b0000001);
    drive(1'b1, 5'd3); tick_check("al_reset");
    check_seg("al_reset_const", segs(), 7'b1111111);
`endif

    // Hold steady: outputs constant over several edges
    drive(1'b0, 5'd13);
    for (int k = 0; k < 3; k++) tick_check("hold_13");

    // Randomized codes with occasional reset
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)));
      tick_check("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
